// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus target: FSM state codes, command/address
// bit positions, register map and register defaults.
package hyperbus_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CA    = 3'd1;
    localparam state_t ST_LAT   = 3'd2;
    localparam state_t ST_WDATA = 3'd3;
    localparam state_t ST_RDATA = 3'd4;
    localparam state_t ST_REGW  = 3'd5;

    // Bit positions inside the 48-bit command/address word
    localparam int CA_RW     = 47;  // 1 = read
    localparam int CA_AS     = 46;  // 1 = register space
    localparam int CA_BT     = 45;  // 1 = linear burst, 0 = wrapped
    localparam int CA_ROW_HI = 44;
    localparam int CA_ROW_LO = 16;
    localparam int CA_COL_HI = 2;

    localparam logic [11:0] REG_ID0 = 12'h000;
    localparam logic [11:0] REG_ID1 = 12'h001;
    localparam logic [11:0] REG_CR0 = 12'h800;

    localparam logic [15:0] ID0_DEFAULT = 16'h0C81;
    localparam logic [15:0] ID1_DEFAULT = 16'h0001;
    localparam logic [15:0] CR0_DEFAULT = 16'h8F1F;

    // Register-space read decode; unmapped addresses read as zero
    function automatic logic [15:0] reg_read(input logic [31:0] a,
                                             input logic [15:0] id0,
                                             input logic [15:0] cr0_v);
        if (a == {20'd0, REG_ID0})      return id0;
        else if (a == {20'd0, REG_ID1}) return ID1_DEFAULT;
        else if (a == {20'd0, REG_CR0}) return cr0_v;
        else                            return 16'h0000;
    endfunction

endpackage

// File: rtl/hb_sync.sv
// Brings the HyperBus pins into the clk domain and turns every hb_ck
// transition into a one-clk pulse with DQ/RWDS aligned to it.
module hb_sync (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       hb_ck,
    input  logic       hb_cs_l,
    input  logic       hb_rst_l,
    input  logic [7:0] hb_dq_in,
    input  logic       hb_rwds_in,
    output logic       ck_edge,
    output logic       ck_rise,
    output logic       cs_l_s,
    output logic       cs_fall,
    output logic       rst_l_s,
    output logic [7:0] dq_s,
    output logic       rwds_s
);

    // [0] metastability stage, [1] synchronized, [2] previous synchronized value
    logic [2:0] ck_sr;
    logic [2:0] cs_sr;
    logic [1:0] rst_sr;
    logic [7:0] dq_m;
    logic       rwds_m;

    // Control synchronizers; CS idles deasserted, device reset idles asserted
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            ck_sr  <= 3'b000;
            cs_sr  <= 3'b111;
            rst_sr <= 2'b00;
        end else begin
            ck_sr  <= {ck_sr[1:0], hb_ck};
            cs_sr  <= {cs_sr[1:0], hb_cs_l};
            rst_sr <= {rst_sr[0], hb_rst_l};
        end
    end

    // Data synchronizers with the same depth as hb_ck so bytes line up with the edge pulse
    always_ff @(posedge clk) begin
        dq_m   <= hb_dq_in;
        dq_s   <= dq_m;
        rwds_m <= hb_rwds_in;
        rwds_s <= rwds_m;
    end

    assign ck_edge = ck_sr[1] ^ ck_sr[2];
    assign ck_rise = ck_sr[1] & ~ck_sr[2];
    assign cs_l_s  = cs_sr[1];
    assign cs_fall = ~cs_sr[1] & cs_sr[2];
    assign rst_l_s = rst_sr[1];

endmodule

// File: rtl/hyperbus_target.sv
// HyperBus target with a 2^MEM_AW x 16 memory and CR0/ID registers. All pin
// activity is oversampled on clk; hb_ck only ever acts through edge pulses.
module hyperbus_target
    import hyperbus_pkg::*;
#(
    parameter int          MEM_AW    = 8,
    parameter int          LAT_EDGES = 22,
    parameter logic [15:0] ID0_VAL   = 16'h0C81,
    parameter logic [15:0] CR0_RST   = 16'h8F1F
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        hb_ck,
    input  logic        hb_cs_l,
    input  logic        hb_rst_l,
    input  logic [7:0]  hb_dq_in,
    output logic [7:0]  hb_dq_out,
    output logic        hb_dq_oe_l,
    input  logic        hb_rwds_in,
    output logic        hb_rwds_out,
    output logic        hb_rwds_oe_l,
    output logic [15:0] cr0,
    output logic        busy
);

    localparam int LCW = (LAT_EDGES < 2) ? 1 : $clog2(LAT_EDGES);

    logic           ck_edge, ck_rise, cs_l_s, cs_fall, rst_l_s, rwds_s;
    logic [7:0]     dq_s;
    state_t         state;
    logic [2:0]     ca_cnt;
    logic [LCW-1:0] lat_cnt;
    logic [39:0]    ca_sr;      // first five CA bytes, oldest in the top byte
    logic           is_read, is_reg, is_linear, regw_done;
    logic [31:0]    addr, addr_next, rd_addr;
    logic [7:0]     hi_byte;
    logic           hi_mask;
    logic [15:0]    rd_word;
    logic [15:0]    mem [0:(1<<MEM_AW)-1];
    logic           abort, lo_edge, mem_we, rd_en;

    hb_sync u_sync (
        .clk        (clk),
        .reset_l    (reset_l),
        .hb_ck      (hb_ck),
        .hb_cs_l    (hb_cs_l),
        .hb_rst_l   (hb_rst_l),
        .hb_dq_in   (hb_dq_in),
        .hb_rwds_in (hb_rwds_in),
        .ck_edge    (ck_edge),
        .ck_rise    (ck_rise),
        .cs_l_s     (cs_l_s),
        .cs_fall    (cs_fall),
        .rst_l_s    (rst_l_s),
        .dq_s       (dq_s),
        .rwds_s     (rwds_s)
    );

    // A deasserted CS or an asserted device reset ends any transaction immediately
    assign abort     = cs_l_s | ~rst_l_s;
    assign lo_edge   = ck_edge & ~ck_rise;
    assign addr_next = is_linear ? addr + 32'd1 : {addr[31:4], addr[3:0] + 4'd1};
    // The read port looks one word ahead while streaming so the next rising edge finds it ready
    assign rd_addr   = (state == ST_RDATA) ? addr_next : addr;
    assign rd_en     = (state == ST_LAT) || (state == ST_RDATA && lo_edge);
    assign mem_we    = (state == ST_WDATA) && lo_edge && !abort;
    assign busy      = (state != ST_IDLE);

    // Transaction FSM, output drivers and CR0
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state        <= ST_IDLE;
            ca_cnt       <= 3'd0;
            lat_cnt      <= '0;
            is_read      <= 1'b0;
            is_reg       <= 1'b0;
            is_linear    <= 1'b0;
            regw_done    <= 1'b0;
            addr         <= 32'd0;
            hb_dq_out    <= 8'h00;
            hb_dq_oe_l   <= 1'b1;
            hb_rwds_out  <= 1'b0;
            hb_rwds_oe_l <= 1'b1;
            cr0          <= CR0_RST;
        end else if (abort) begin
            state        <= ST_IDLE;
            ca_cnt       <= 3'd0;
            lat_cnt      <= '0;
            regw_done    <= 1'b0;
            hb_dq_oe_l   <= 1'b1;
            hb_rwds_out  <= 1'b0;
            hb_rwds_oe_l <= 1'b1;
            if (!rst_l_s) cr0 <= CR0_RST;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state        <= ST_CA;
                        ca_cnt       <= 3'd0;
                        // RWDS high during CA advertises the fixed 2x latency
                        hb_rwds_out  <= 1'b1;
                        hb_rwds_oe_l <= 1'b0;
                    end
                end
                ST_CA: begin
                    if (ck_edge) begin
                        ca_cnt <= ca_cnt + 3'd1;
                        if (ca_cnt == 3'd5) begin
                            ca_cnt       <= 3'd0;
                            lat_cnt      <= '0;
                            is_read      <= ca_sr[CA_RW-8];
                            is_reg       <= ca_sr[CA_AS-8];
                            is_linear    <= ca_sr[CA_BT-8];
                            addr         <= {ca_sr[CA_ROW_HI-8:CA_ROW_LO-8], dq_s[CA_COL_HI:0]};
                            hb_rwds_out  <= 1'b0;
                            hb_rwds_oe_l <= 1'b1;
                            // Register writes carry no latency
                            if (ca_sr[CA_AS-8] && !ca_sr[CA_RW-8]) state <= ST_REGW;
                            else                                   state <= ST_LAT;
                        end
                    end
                end
                ST_LAT: begin
                    if (ck_edge) begin
                        if (lat_cnt == LCW'(LAT_EDGES - 1)) begin
                            lat_cnt <= '0;
                            if (is_read) begin
                                state        <= ST_RDATA;
                                hb_dq_oe_l   <= 1'b0;
                                hb_rwds_oe_l <= 1'b0;
                            end else begin
                                state <= ST_WDATA;
                            end
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (lo_edge) addr <= addr_next;
                end
                ST_RDATA: begin
                    if (ck_edge) begin
                        if (ck_rise) begin
                            hb_dq_out   <= rd_word[15:8];
                            hb_rwds_out <= 1'b1;
                        end else begin
                            hb_dq_out   <= rd_word[7:0];
                            hb_rwds_out <= 1'b0;
                            addr        <= addr_next;
                        end
                    end
                end
                ST_REGW: begin
                    // Only the first word counts; later edges are ignored until CS rises
                    if (lo_edge && !regw_done) begin
                        regw_done <= 1'b1;
                        if (addr == {20'd0, REG_CR0}) cr0 <= {hi_byte, dq_s};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // CA shifter, high-byte capture, byte-masked memory write and registered read
    always_ff @(posedge clk) begin
        if (state == ST_CA && ck_edge) ca_sr <= {ca_sr[31:0], dq_s};
        if ((state == ST_WDATA || state == ST_REGW) && ck_edge && ck_rise) begin
            hi_byte <= dq_s;
            hi_mask <= rwds_s;
        end
        if (mem_we) begin
            if (!hi_mask) mem[addr[MEM_AW-1:0]][15:8] <= hi_byte;
            if (!rwds_s)  mem[addr[MEM_AW-1:0]][7:0]  <= dq_s;
        end
        if (rd_en) begin
            rd_word <= is_reg ? reg_read(rd_addr, ID0_VAL, cr0) : mem[rd_addr[MEM_AW-1:0]];
        end
    end

endmodule

// File: doc/hyperbus_target.md
HYPERBUS_TARGET -- requirements
Module: hyperbus_target

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, giving a memory depth of 2^MEM_AW 16-bit words.
REQ-002 SHALL have parameter LAT_EDGES, default 22: the number of hb_ck edges between the last CA edge and the first data edge.
REQ-003 SHALL have parameter ID0_VAL, default 16'h0C81, the ID register 0 value.
REQ-004 SHALL have parameter CR0_RST, default 16'h8F1F, the CR0 reset value.
REQ-005 SHALL have port clk, input, 1 bit: single system clock, at least 4x the hb_ck frequency; all logic runs on it.
REQ-006 SHALL have port reset_l, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port hb_ck, input, 1 bit: HyperBus clock from the controller; it is oversampled.
REQ-008 SHALL have port hb_cs_l, input, 1 bit: chip select, active low.
REQ-009 SHALL have port hb_rst_l, input, 1 bit: device reset from the controller, active low.
REQ-010 SHALL have port hb_dq_in, input, 8 bits: DQ bus sampled from the pins.
REQ-011 SHALL have port hb_dq_out, output, 8 bits: DQ drive value.
REQ-012 SHALL have port hb_dq_oe_l, output, 1 bit: DQ output enable, active low.
REQ-013 SHALL have port hb_rwds_in, input, 1 bit: RWDS sampled; it is the write byte mask.
REQ-014 SHALL have port hb_rwds_out, output, 1 bit: RWDS drive value.
REQ-015 SHALL have port hb_rwds_oe_l, output, 1 bit: RWDS output enable, active low.
REQ-016 SHALL have port cr0, output, 16 bits: current configuration register 0.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-018 SHALL pass hb_ck, hb_cs_l, hb_dq_in and hb_rwds_in through a 2-flop synchronizer, then detect each hb_ck edge (rise or fall) as a one-clk pulse; DQ and RWDS are sampled aligned to that pulse.
REQ-019 SHALL implement FSM states IDLE, CA, LAT, WDATA, RDATA, REGW.
REQ-020 SHALL enter CA from IDLE when synchronized hb_cs_l falls.
REQ-021 SHALL, in CA, shift in 6 bytes MSB-first on 6 edges to build CA[47:0]; CA[47]=1 is a read, CA[46]=1 is register space, CA[45]=1 is a linear burst and 0 a wrapped burst; word address = {CA[44:16], CA[2:0]}, truncated to MEM_AW bits.
REQ-022 SHALL drive hb_rwds_out=1 with hb_rwds_oe_l=0 throughout CA, signalling 2x latency.
REQ-023 SHALL go from CA to REGW on the 6th edge for a register-space write (zero latency); otherwise to LAT.
REQ-024 SHALL, in LAT, count LAT_EDGES edges, then go to RDATA (read) or WDATA (write).
REQ-025 SHALL, in WDATA, take the rising-edge byte as data[15:8] and the falling-edge byte as data[7:0].
REQ-026 SHALL, in WDATA, treat hb_rwds_in=1 on a byte's edge as masking that byte; memory SHALL be written only on the falling edge, with the full masked word.
REQ-027 SHALL, in RDATA, drive hb_dq_out = word[15:8] on each rising-edge pulse and word[7:0] on each falling-edge pulse.
REQ-028 SHALL, in RDATA, drive hb_rwds_out = 1 with the high byte and 0 with the low byte, and hold hb_dq_oe_l=0 and hb_rwds_oe_l=0.
REQ-029 SHALL increment the address after each word.
REQ-030 SHALL, for a linear burst, wrap the address at 2^MEM_AW; for a wrapped burst, wrap addr[3:0] within the aligned 16-word group.
REQ-031 SHALL decode register reads as: addr 0 returns ID0_VAL, addr 1 returns 16'h0001, addr 12'h800 returns cr0, any other addr returns 16'h0000.
REQ-032 SHALL, in REGW, load one word into cr0 when addr = 12'h800; writes to any other register address are ignored; REGW then holds until CS rises.
REQ-033 SHALL, whenever synchronized hb_cs_l is high in any state, go to IDLE on the next clk, release both output enables, and discard any partial word.
REQ-034 SHALL treat hb_rst_l low like CS high and additionally load cr0 with CR0_RST.
REQ-035 SHALL make memory reads combinational-free: one registered read, prefetched in the LAT state and at each low-byte edge.

Reset
REQ-036 SHALL, on reset_l low, asynchronously force: state=IDLE, hb_dq_oe_l=1, hb_rwds_oe_l=1, hb_dq_out=8'h00, hb_rwds_out=0, cr0=CR0_RST, busy=0, all counters 0; memory contents are undefined.

Structure
REQ-037 SHALL place the FSM state enum, CA bit indices, register addresses (ID0=0, ID1=1, CR0=12'h800) and the CR0/ID defaults in package hyperbus_pkg.
REQ-038 SHALL contain one sub-module, hb_sync, covering the synchronizer and the hb_ck edge detector.

Verification
REQ-039 SHALL cover reset: hold reset_l low -> hb_dq_oe_l=1, hb_rwds_oe_l=1, cr0=16'h8F1F, busy=0.
REQ-040 SHALL cover linear write then read: write CA 48'h2000_0000_0003 with words A5A5, 1234 and RWDS=0; then read CA 48'hA000_0000_0003 -> A5A5 then 1234, first byte on the 23rd edge after CA, RWDS toggling.
REQ-041 SHALL cover byte mask: write 16'hFFFF to word 3 with RWDS=1 on the high byte -> a readback of word 3 = 16'hA5FF.
REQ-042 SHALL cover register write and ID read: write CA 48'h6000_0100_0000 with data 16'h8F17 -> cr0=16'h8F17; then read CA 48'hE000_0000_0000 -> 16'h0C81.
REQ-043 SHALL cover wrapped burst: read CA[45]=0 at word 8'h0E for 4 words -> addresses 0E, 0F, 00, 01.
REQ-044 SHALL cover CS abort: raise hb_cs_l after the first write byte -> memory unchanged, both OEs released within 3 clk, and the next transaction completes correctly.
